// File: rtl/ternary_consensus_arbiter.sv
// Round-robin shared ternary consensus unit with a one-entry valid/ready result register.
// Optional TERN_CHECK_EN adds res_err and forces illegal (2'b11) trits to '0'.

module ternary_consensus (
  input  logic [1:0] a,
  input  logic [1:0] b,
`ifdef TERN_CHECK_EN
  output logic       bad,
`endif
  output logic [1:0] y
);
`ifdef TERN_CHECK_EN
  assign bad = (a == 2'b11) || (b == 2'b11);
  assign y   = bad ? 2'b01 : ((a == b) ? a : 2'b01);
`else
  assign y   = (a == b) ? a : 2'b01;
`endif
endmodule

// state | meaning
// EMPTY | result register holds nothing; any pending request may be granted
// FULL  | res_data/res_id valid; refill allowed only in the cycle it drains
module ternary_consensus_arbiter #(
  parameter int NREQ  = 4,
  parameter int TRITS = 4,
  parameter int CNTW  = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*2*TRITS-1:0] req_a,
  input  logic [NREQ*2*TRITS-1:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*TRITS-1:0]      res_data,
  output logic [IDW-1:0]          res_id,
`ifdef TERN_CHECK_EN
  output logic                    res_err,
`endif
  output logic [CNTW-1:0]         done_cnt,
  output logic                    busy
);
  localparam int OPW = 2 * TRITS;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           found;
  logic           can_accept;
  logic           accept;
  logic           drain;
  int             scan;
  logic [OPW-1:0] win_a;
  logic [OPW-1:0] win_b;
  logic [OPW-1:0] cons;
`ifdef TERN_CHECK_EN
  logic [TRITS-1:0] trit_bad;
`endif

  assign res_valid  = (state == FULL);
  assign can_accept = !res_valid || res_ready;
  assign drain      = res_valid && res_ready;
  assign accept     = found && can_accept;
  assign busy       = res_valid || (|req_valid);

  // Scan from rr_ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!found && req_valid[IDW'(scan)]) begin
        found  = 1'b1;
        winner = IDW'(scan);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  assign win_a = req_a[int'(winner)*OPW +: OPW];
  assign win_b = req_b[int'(winner)*OPW +: OPW];

  for (genvar t = 0; t < TRITS; t++) begin : g_trit
    ternary_consensus u_cell (
      .a   (win_a[2*t +: 2]),
      .b   (win_b[2*t +: 2]),
`ifdef TERN_CHECK_EN
      .bad (trit_bad[t]),
`endif
      .y   (cons[2*t +: 2])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      res_data <= {TRITS{2'b01}};
      res_id   <= '0;
      rr_ptr   <= '0;
      done_cnt <= '0;
`ifdef TERN_CHECK_EN
      res_err  <= 1'b0;
`endif
    end else begin
      if (drain) done_cnt <= done_cnt + CNTW'(1);
      if (accept) begin
        state    <= FULL;
        res_data <= cons;
        res_id   <= winner;
        rr_ptr   <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
`ifdef TERN_CHECK_EN
        res_err  <= |trit_bad;
`endif
      end else if (drain) begin
        state <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_ternary_consensus_arbiter.sv
// Scoreboard bench for ternary_consensus_arbiter: directed cases then randomized traffic.
// A reference model predicts grants/results; a monitor pops and compares on each handshake.

module tb_ternary_consensus_arbiter;
  localparam int NREQ  = 4;
  localparam int TRITS = 4;
  localparam int CNTW  = 4;
  localparam int IDW   = $clog2(NREQ);
  localparam int OPW   = 2 * TRITS;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*OPW-1:0]   req_a;
  logic [NREQ*OPW-1:0]   req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [OPW-1:0]        res_data;
  logic [IDW-1:0]        res_id;
  logic [CNTW-1:0]       done_cnt;
  logic                  busy;
`ifdef TERN_CHECK_EN
  logic                  res_err;
`endif

  ternary_consensus_arbiter #(.NREQ(NREQ), .TRITS(TRITS), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
`ifdef TERN_CHECK_EN
    .res_err   (res_err),
`endif
    .done_cnt  (done_cnt),
    .busy      (busy)
  );

  typedef struct packed {
    logic [OPW-1:0] data;
    logic [IDW-1:0] id;
    logic           err;
  } exp_t;

  exp_t            exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  logic            m_full;
  int              m_ptr;
  logic [NREQ-1:0] acc_mask;
  int              exp_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_result(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                        input int id);
    exp_t r;
    int   ta, tb_, o;
    r.data = '0;
    r.id   = IDW'(id);
    r.err  = 1'b0;
    for (int t = 0; t < TRITS; t++) begin
      ta  = int'(a >> (2*t)) % 4;
      tb_ = int'(b >> (2*t)) % 4;
`ifdef TERN_CHECK_EN
      if (ta == 3 || tb_ == 3) begin
        r.err = 1'b1;
        o = 1;
      end else begin
        o = (ta == tb_) ? ta : 1;
      end
`else
      o = (ta == tb_) ? ta : 1;
`endif
      r.data = r.data | (OPW'(o) << (2*t));
    end
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Reference model: predicts the grant and pushes the result that the next edge loads.
  initial begin
    int              w;
    logic [NREQ-1:0] exp_rdy;
    m_full   = 1'b0;
    m_ptr    = 0;
    acc_mask = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_full   = 1'b0;
        m_ptr    = 0;
        acc_mask = '0;
      end else begin
        chk("res_valid", 32'(res_valid), 32'(m_full));
        chk("busy", 32'(busy), 32'(m_full | (|req_valid)));
        w        = rr_pick(req_valid, m_ptr);
        exp_rdy  = '0;
        acc_mask = '0;
        if (w >= 0 && (!m_full || res_ready)) begin
          exp_rdy[w] = 1'b1;
          acc_mask   = exp_rdy;
          exp_q.push_back(model_result(req_a[w*OPW +: OPW], req_b[w*OPW +: OPW], w));
          m_full = 1'b1;
          m_ptr  = (w + 1) % NREQ;
        end else if (m_full && res_ready) begin
          m_full = 1'b0;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      end
    end
  end

  // Monitor: compares the presented result whenever a handshake is about to happen.
  initial begin
    exp_t e;
    exp_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_done = 0;
      end else begin
        chk("done_cnt", 32'(done_cnt), 32'(exp_done % (1 << CNTW)));
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_unexpected: got data %0h id %0d expected no result", res_data, res_id);
          end else begin
            e = exp_q.pop_front();
            chk("res_data", 32'(res_data), 32'(e.data));
            chk("res_id", 32'(res_id), 32'(e.id));
`ifdef TERN_CHECK_EN
            chk("res_err", 32'(res_err), 32'(e.err));
`endif
          end
          exp_done++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic set_req(input int i, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    req_a[i*OPW +: OPW] = a;
    req_b[i*OPW +: OPW] = b;
    req_valid[i]        = 1'b1;
  endtask

  initial begin
    int waitc;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(res_valid), 32'(0));
    chk("rst_data", 32'(res_data), 32'(8'h55));
    chk("rst_id", 32'(res_id), 32'(0));
    chk("rst_done", 32'(done_cnt), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    rst_n = 1'b1;

    // single request
    set_req(0, 8'b10_01_00_10, 8'b10_00_00_01);
    res_ready = 1'b1;
    step();
    @(negedge clk);
    chk("single_data", 32'(res_data), 32'(8'b10_01_00_01));
    chk("single_id", 32'(res_id), 32'(0));

    // backpressure: hold 8'hAA while req2 waits
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    set_req(1, 8'hAA, 8'hAA);
    step();
    set_req(2, 8'b10_00_01_10, 8'b10_01_01_00);
    @(negedge clk);
    chk("bp_ready", 32'(req_ready), 32'(0));
    chk("bp_hold", 32'(res_data), 32'(8'hAA));
    step();
    @(negedge clk);
    chk("bp_hold2", 32'(res_data), 32'(8'hAA));
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'(4'b0100));
    step();
    @(negedge clk);
    chk("bp_refill", 32'(res_data), 32'(8'h95));
    chk("bp_refill_id", 32'(res_id), 32'(2));

    // illegal trits
    @(posedge clk);
    #1;
    set_req(3, 8'b11_10_10_10, 8'b11_10_00_10);
    step();
    @(negedge clk);
`ifdef TERN_CHECK_EN
    chk("tern_data", 32'(res_data), 32'(8'b01_10_01_10));
    chk("tern_err", 32'(res_err), 32'(1));
`else
    chk("tern_data", 32'(res_data), 32'(8'b11_10_01_10));
`endif

    // reset while FULL
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    set_req(0, 8'h11, 8'h11);
    step();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("midrst_valid", 32'(res_valid), 32'(0));
    chk("midrst_data", 32'(res_data), 32'(8'h55));
    chk("midrst_done", 32'(done_cnt), 32'(0));
    chk("midrst_id", 32'(res_id), 32'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // round robin with all requesters active
    for (int i = 0; i < NREQ; i++) set_req(i, OPW'($urandom), OPW'($urandom));
    res_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (n % NREQ)));
      step();
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i]) set_req(i, OPW'($urandom), OPW'($urandom));
    end
    req_valid = '0;
    step();
    @(negedge clk);
    chk("rr_done", 32'(done_cnt), 32'(5));

    // counter wrap at 2^CNTW
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int n = 0; n < 17; n++) begin
      set_req(0, OPW'($urandom), OPW'($urandom));
      step();
    end
    req_valid = '0;
    step();
    @(negedge clk);
    chk("wrap_done", 32'(done_cnt), 32'(1));

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, OPW'($urandom), OPW'($urandom));
      res_ready = ($urandom_range(0, 3) != 0);
    end

    // drain with a bounded wait
    step();
    req_valid = '0;
    res_ready = 1'b1;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);
    chk("drain_valid", 32'(res_valid), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
